// File: rtl/chacha20_stream_ctrl.sv
// ChaCha20 session controller: builds core input state, sequences the
// block core and streams 512-bit keystream blocks over valid/ready.
module chacha20_stream_ctrl #(
  parameter int TRNG_TIMEOUT = 1024,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sess_start,
  input  logic             sess_abort,
  input  logic [255:0]     key_in,
  input  logic [95:0]      nonce_in,
  input  logic             nonce_src,
  input  logic [31:0]      ctr_init,
  input  logic [CNT_W-1:0] num_blocks,
  output logic             busy,
  output logic             sess_done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [95:0]      nonce_out,
  output logic             trng_request,
  input  logic [31:0]      trng_data,
  input  logic             trng_ready,
  output logic             core_start,
  input  logic             core_done,
  output logic [511:0]     core_in_state,
  input  logic [511:0]     core_out_state,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic [511:0]     ks_data
);

  localparam int TW = $clog2(TRNG_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NONCE,
    S_LOAD,
    S_WAIT,
    S_OUT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [255:0]     r_key;
  logic [95:0]      r_nonce;
  logic [31:0]      r_ctr;
  logic [CNT_W-1:0] r_rem;
  logic [TW-1:0]    r_tmo;
  logic [1:0]       r_widx;
  logic [511:0]     r_core_in;
  logic [511:0]     r_ks_data;
  logic             r_done;
  logic             r_err;
  logic [1:0]       r_err_code;

  logic w_start_ok;
  logic w_abort;
  logic w_trng_last;
  logic w_tmo;
  logic w_hs;
  logic w_last;
  logic w_wrap;
  logic w_adv;

  function automatic logic [511:0] f_pack(
    input logic [255:0] key,
    input logic [31:0]  ctr,
    input logic [95:0]  nonce
  );
    return {32'h61707865, 32'h3320646e,
            32'h79622d32, 32'h6b206574,
            key, ctr, nonce};
  endfunction

  assign w_start_ok  = (r_state == S_IDLE) && sess_start;
  assign w_abort     = (r_state != S_IDLE) && sess_abort;
  assign w_trng_last = (r_state == S_NONCE) && trng_ready
                       && (r_widx == 2'd2);
  assign w_tmo       = (r_state == S_NONCE) && !trng_ready
                       && (r_tmo == TW'(TRNG_TIMEOUT - 1));
  assign w_hs        = (r_state == S_OUT) && ks_ready;
  assign w_last      = w_hs && (r_rem == CNT_W'(1));
  assign w_wrap      = w_hs && (r_rem != CNT_W'(1))
                       && (r_ctr == 32'hFFFFFFFF);
  assign w_adv       = w_hs && !w_last && !w_wrap;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state selection; abort overrides every non-idle transition
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (sess_start && (num_blocks != '0))
          w_next = nonce_src ? S_NONCE : S_LOAD;
      end
      S_NONCE: begin
        if (w_trng_last) w_next = S_LOAD;
        else if (w_tmo)  w_next = S_IDLE;
      end
      S_LOAD: w_next = S_WAIT;
      S_WAIT: if (core_done) w_next = S_OUT;
      S_OUT: begin
        if (w_last || w_wrap) w_next = S_IDLE;
        else if (w_adv)       w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  // Session datapath: latches, nonce fill, counters, capture, status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key      <= '0;
      r_nonce    <= '0;
      r_ctr      <= '0;
      r_rem      <= '0;
      r_tmo      <= '0;
      r_widx     <= '0;
      r_core_in  <= '0;
      r_ks_data  <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
    end else begin
      r_done <= 1'b0;
      if (w_start_ok) begin
        r_key      <= key_in;
        r_ctr      <= ctr_init;
        r_rem      <= num_blocks;
        r_nonce    <= nonce_in;
        r_err      <= 1'b0;
        r_err_code <= 2'd0;
        r_widx     <= '0;
        r_tmo      <= '0;
        if (num_blocks == '0)
          r_done <= 1'b1;
        else if (!nonce_src)
          r_core_in <= f_pack(key_in, ctr_init, nonce_in);
      end else if (!w_abort) begin
        unique case (r_state)
          S_NONCE: begin
            if (trng_ready) begin
              unique case (r_widx)
                2'd0:    r_nonce[95:64] <= trng_data;
                2'd1:    r_nonce[63:32] <= trng_data;
                default: r_nonce[31:0]  <= trng_data;
              endcase
              r_widx <= r_widx + 2'd1;
              r_tmo  <= '0;
              if (w_trng_last)
                r_core_in <= f_pack(r_key, r_ctr,
                                    {r_nonce[95:32], trng_data});
            end else if (w_tmo) begin
              r_err      <= 1'b1;
              r_err_code <= 2'd1;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
          S_WAIT: begin
            if (core_done) r_ks_data <= core_out_state;
          end
          S_OUT: begin
            if (w_hs) r_rem <= r_rem - CNT_W'(1);
            if (w_last) begin
              r_done <= 1'b1;
            end else if (w_wrap) begin
              r_err      <= 1'b1;
              r_err_code <= 2'd2;
            end else if (w_adv) begin
              r_ctr     <= r_ctr + 32'd1;
              r_core_in <= f_pack(r_key, r_ctr + 32'd1, r_nonce);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign trng_request  = (r_state == S_NONCE);
  assign core_start    = (r_state == S_LOAD);
  assign ks_valid      = (r_state == S_OUT);
  assign ks_data       = r_ks_data;
  assign core_in_state = r_core_in;
  assign sess_done     = r_done;
  assign err           = r_err;
  assign err_code      = r_err_code;
  assign nonce_out     = r_nonce;

endmodule
